// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the 32x32 register file: buffers producer results, drains one per
// cycle and forwards pending data. Optional macro WBQ_COALESCE_EN merges same-register pushes.
module regfile_wb_queue #(
    parameter int unsigned ADDR_BUS_WIDTH = 5,
    parameter int unsigned DATA_BUS_WIDTH = 32,
    parameter int unsigned DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_BUS_WIDTH-1:0] in_addr,
    input  logic [DATA_BUS_WIDTH-1:0] in_data,
    input  logic                      drain_stall,
    output logic                      wb_en,
    output logic [ADDR_BUS_WIDTH-1:0] wb_addr,
    output logic [DATA_BUS_WIDTH-1:0] wb_data,
    input  logic [ADDR_BUS_WIDTH-1:0] fwd_addr1,
    input  logic [ADDR_BUS_WIDTH-1:0] fwd_addr2,
    output logic                      fwd_hit1,
    output logic                      fwd_hit2,
    output logic [DATA_BUS_WIDTH-1:0] fwd_data1,
    output logic [DATA_BUS_WIDTH-1:0] fwd_data2,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_BUS_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_BUS_WIDTH-1:0] data_q [DEPTH];

    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, young_idx, scan_idx;
    logic [CntW-1:0] count_q, count_d;
    logic            full, empty, pop, push_acc, alloc, coalesce, young_match;

    assign full      = (count_q == CntW'(DEPTH));
    assign empty     = (count_q == '0);
    assign wb_en     = !empty && !drain_stall;
    assign pop       = wb_en;
    assign count     = count_q;
    assign young_idx = tail_q - PtrW'(1);

    // Stored entries never hold x0, but keep the guard so a stale slot can never match.
    assign young_match = !empty && (in_addr != '0) && (addr_q[young_idx] == in_addr);

`ifdef WBQ_COALESCE_EN
    // The youngest entry is only popped when it is also the head, i.e. count == 1.
    assign coalesce = in_valid && young_match && !(pop && (count_q == CntW'(1)));
    assign in_ready = !full || coalesce;
`else
    assign coalesce = 1'b0;
    assign in_ready = !full;
`endif

    assign push_acc = in_valid && in_ready;
    assign alloc    = push_acc && (in_addr != '0) && !coalesce;

    assign wb_addr = empty ? '0 : addr_q[head_q];
    assign wb_data = empty ? '0 : data_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + PtrW'(1);
        end
        if (alloc) begin
            tail_d = tail_q + PtrW'(1);
        end
        unique case ({alloc, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset; validity is tracked purely by head/count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (alloc) begin
                addr_q[tail_q] <= in_addr;
                data_q[tail_q] <= in_data;
            end else if (coalesce) begin
                data_q[young_idx] <= in_data;
            end
        end
    end

    // Scan oldest to youngest so the last match seen wins.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        scan_idx  = head_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            scan_idx = head_q + PtrW'(i);
            if (CntW'(i) < count_q) begin
                if ((fwd_addr1 != '0) && (addr_q[scan_idx] == fwd_addr1)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_q[scan_idx];
                end
                if ((fwd_addr2 != '0) && (addr_q[scan_idx] == fwd_addr2)) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = data_q[scan_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed vector bench for regfile_wb_queue: table-driven cycles plus hand-written sequences
// for youngest-match forwarding and same-register back-to-back pushes.
module tb_regfile_wb_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        drain_stall;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  fwd_addr1;
    logic [4:0]  fwd_addr2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;

`ifdef WBQ_COALESCE_EN
    localparam bit Coal = 1'b1;
`else
    localparam bit Coal = 1'b0;
`endif

    regfile_wb_queue #(
        .ADDR_BUS_WIDTH(5),
        .DATA_BUS_WIDTH(32),
        .DEPTH         (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .drain_stall(drain_stall),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .fwd_addr1  (fwd_addr1),
        .fwd_addr2  (fwd_addr2),
        .fwd_hit1   (fwd_hit1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        stall;
        logic [4:0]  fa1;
        logic [4:0]  fa2;
        logic        e_ready;
        logic        e_wb_en;
        logic [4:0]  e_wb_addr;
        logic [31:0] e_wb_data;
        logic        e_hit1;
        logic [31:0] e_d1;
        logic        e_hit2;
        logic [31:0] e_d2;
        logic [2:0]  e_count;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic s, input logic [4:0] f1, input logic [4:0] f2,
                       input logic rdy, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic h1, input logic [31:0] d1,
                       input logic h2, input logic [31:0] d2, input logic [2:0] c);
        vec_t t;
        t.rst = r;  t.vld = v;  t.addr = a;  t.data = d;  t.stall = s;  t.fa1 = f1;  t.fa2 = f2;
        t.e_ready = rdy;  t.e_wb_en = we;  t.e_wb_addr = wa;  t.e_wb_data = wd;
        t.e_hit1 = h1;  t.e_d1 = d1;  t.e_hit2 = h2;  t.e_d2 = d2;  t.e_count = c;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Inputs change just after negedge; outputs are sampled 1 time unit later.
    task automatic drive(input logic r, input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic s, input logic [4:0] f1, input logic [4:0] f2);
        @(negedge clk);
        rst = r;  in_valid = v;  in_addr = a;  in_data = d;  drain_stall = s;
        fwd_addr1 = f1;  fwd_addr2 = f2;
        #1;
    endtask

    initial begin
        rst = 1'b1;  in_valid = 1'b0;  in_addr = '0;  in_data = '0;  drain_stall = 1'b0;
        fwd_addr1 = '0;  fwd_addr2 = '0;
        repeat (2) @(posedge clk);

        //  r  v  addr  data          s  f1  f2   rdy we wa  wd           h1 d1       h2 d2    cnt
        // Reset state, single push latency, head still forwards while draining
        add(0, 0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0,  0);
        add(0, 1, 5, 32'h6,        0, 5, 0,  1, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0,  0);
        add(0, 0, 0, 32'h0,        0, 5, 0,  1, 1, 5, 32'h6,        1, 32'h6,    0, 32'h0,  1);
        add(0, 0, 0, 32'h0,        0, 5, 0,  1, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0,  0);
        // Fill under stall, backpressure, then in-order drain
        add(0, 1, 1, 32'h11,       1, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0,  0);
        add(0, 1, 2, 32'h22,       1, 0, 0,  1, 0, 1, 32'h11,       0, 32'h0,    0, 32'h0,  1);
        add(0, 1, 3, 32'h33,       1, 0, 0,  1, 0, 1, 32'h11,       0, 32'h0,    0, 32'h0,  2);
        add(0, 1, 4, 32'h44,       1, 0, 0,  1, 0, 1, 32'h11,       0, 32'h0,    0, 32'h0,  3);
        add(0, 1, 5, 32'h55,       1, 3, 4,  0, 0, 1, 32'h11,       1, 32'h33,   1, 32'h44, 4);
        add(0, 1, 5, 32'h55,       0, 0, 0,  0, 1, 1, 32'h11,       0, 32'h0,    0, 32'h0,  4);
        add(0, 1, 5, 32'h55,       0, 0, 0,  1, 1, 2, 32'h22,       0, 32'h0,    0, 32'h0,  3);
        add(0, 0, 0, 32'h0,        0, 5, 0,  1, 1, 3, 32'h33,       1, 32'h55,   0, 32'h0,  3);
        add(0, 0, 0, 32'h0,        0, 0, 0,  1, 1, 4, 32'h44,       0, 32'h0,    0, 32'h0,  2);
        add(0, 0, 0, 32'h0,        0, 0, 0,  1, 1, 5, 32'h55,       0, 32'h0,    0, 32'h0,  1);
        add(0, 0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0,  0);
        // x0 push is accepted but never stored
        add(0, 1, 0, 32'hDEADBEEF, 0, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0,  0);
        add(0, 0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0,  0);
        // Forwarding hit/miss on two ports, then drain
        add(0, 1, 9, 32'h2004,     1, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0,  0);
        add(0, 1, 6, 32'h60,       1, 9, 7,  1, 0, 9, 32'h2004,     1, 32'h2004, 0, 32'h0,  1);
        add(0, 0, 0, 32'h0,        1, 9, 6,  1, 0, 9, 32'h2004,     1, 32'h2004, 1, 32'h60, 2);
        add(0, 0, 0, 32'h0,        0, 0, 0,  1, 1, 9, 32'h2004,     0, 32'h0,    0, 32'h0,  2);
        add(0, 0, 0, 32'h0,        0, 0, 0,  1, 1, 6, 32'h60,       0, 32'h0,    0, 32'h0,  1);
        add(0, 0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0,  0);
        // Fill, stream push+pop, reset mid-stream
        add(0, 1, 1, 32'hA1,       1, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0,  0);
        add(0, 1, 2, 32'hA2,       1, 0, 0,  1, 0, 1, 32'hA1,       0, 32'h0,    0, 32'h0,  1);
        add(0, 1, 3, 32'hA3,       1, 0, 0,  1, 0, 1, 32'hA1,       0, 32'h0,    0, 32'h0,  2);
        add(0, 1, 4, 32'hA4,       1, 0, 0,  1, 0, 1, 32'hA1,       0, 32'h0,    0, 32'h0,  3);
        add(0, 1, 5, 32'hA5,       0, 0, 0,  0, 1, 1, 32'hA1,       0, 32'h0,    0, 32'h0,  4);
        add(0, 1, 5, 32'hA5,       0, 0, 0,  1, 1, 2, 32'hA2,       0, 32'h0,    0, 32'h0,  3);
        add(0, 1, 6, 32'hA6,       0, 0, 0,  1, 1, 3, 32'hA3,       0, 32'h0,    0, 32'h0,  3);
        add(1, 1, 7, 32'hA7,       0, 0, 0,  1, 1, 4, 32'hA4,       0, 32'h0,    0, 32'h0,  3);
        add(0, 0, 0, 32'h0,        0, 5, 6,  1, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0,  0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].addr, vecs[i].data, vecs[i].stall,
                  vecs[i].fa1, vecs[i].fa2);
            check("in_ready",  i, 32'(in_ready),  32'(vecs[i].e_ready));
            check("wb_en",     i, 32'(wb_en),     32'(vecs[i].e_wb_en));
            check("wb_addr",   i, 32'(wb_addr),   32'(vecs[i].e_wb_addr));
            check("wb_data",   i, wb_data,        vecs[i].e_wb_data);
            check("fwd_hit1",  i, 32'(fwd_hit1),  32'(vecs[i].e_hit1));
            check("fwd_data1", i, fwd_data1,      vecs[i].e_d1);
            check("fwd_hit2",  i, 32'(fwd_hit2),  32'(vecs[i].e_hit2));
            check("fwd_data2", i, fwd_data2,      vecs[i].e_d2);
            check("count",     i, 32'(count),     32'(vecs[i].e_count));
        end

        // Same register pushed twice: youngest wins on forwarding; drain shape depends on build
        drive(1, 0, 0, 32'h0, 1, 0, 0);
        drive(0, 1, 9, 32'h2004, 1, 0, 0);
        check("seq9_count0", 100, 32'(count), 32'd0);
        drive(0, 1, 9, 32'h3000, 1, 0, 0);
        check("seq9_ready", 101, 32'(in_ready), 32'd1);
        drive(0, 0, 0, 32'h0, 1, 9, 7);
        check("seq9_hit1",  102, 32'(fwd_hit1), 32'd1);
        check("seq9_data1", 102, fwd_data1, 32'h3000);
        check("seq9_hit2",  102, 32'(fwd_hit2), 32'd0);
        check("seq9_data2", 102, fwd_data2, 32'h0);
        check("seq9_count", 102, 32'(count), Coal ? 32'd1 : 32'd2);
        drive(0, 0, 0, 32'h0, 0, 0, 0);
        check("seq9_wb_en0",   103, 32'(wb_en), 32'd1);
        check("seq9_wb_addr0", 103, 32'(wb_addr), 32'd9);
        check("seq9_wb_data0", 103, wb_data, Coal ? 32'h3000 : 32'h2004);
        drive(0, 0, 0, 32'h0, 0, 0, 0);
        check("seq9_wb_en1",   104, 32'(wb_en), Coal ? 32'd0 : 32'd1);
        check("seq9_wb_data1", 104, wb_data, Coal ? 32'h0 : 32'h3000);
        check("seq9_count1",   104, 32'(count), Coal ? 32'd0 : 32'd1);
        drive(0, 0, 0, 32'h0, 0, 0, 0);
        check("seq9_empty", 105, 32'(count), 32'd0);

        // Second same-register pair, queue left empty afterwards
        drive(0, 1, 3, 32'hA, 1, 0, 0);
        drive(0, 1, 3, 32'hB, 1, 3, 0);
        check("seq3_fwd", 110, fwd_data1, 32'hA);
        drive(0, 0, 0, 32'h0, 0, 3, 0);
        check("seq3_count", 111, 32'(count), Coal ? 32'd1 : 32'd2);
        check("seq3_wb_data0", 111, wb_data, Coal ? 32'hB : 32'hA);
        check("seq3_fwd_young", 111, fwd_data1, 32'hB);
        drive(0, 0, 0, 32'h0, 0, 0, 0);
        check("seq3_wb_en1", 112, 32'(wb_en), Coal ? 32'd0 : 32'd1);
        check("seq3_wb_data1", 112, wb_data, Coal ? 32'h0 : 32'hB);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
